led_bar_decoder: RTL and testbench

Receive-side counterpart of the 8-LED fill/empty bar generator. It samples the 8-bit bar pattern, de-glitches it and checks that it is a legal thermometer pattern. It tracks the fill/empty sequence and recovers level, direction and the underlying 4-bit phase count. Step and error pulses plus a saturating error counter are exported for the test harness and the on-board status display.

---
 rtl/led_bar_decoder.sv | 201 ++++++++++++++++++++
 tb/tb_led_bar_decoder.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/led_bar_decoder.sv
// led_bar_decoder: receive-side decoder for the 8-LED fill/empty bar generator.
// It synchronizes and de-glitches the bar pattern and checks that it is a legal
// thermometer code. It follows the fill/empty sequence and recovers level,
// direction and the 4-bit phase count of the generator.
// Ports:
//   CLK      system clock, rising edge
//   nrst     asynchronous active-low reset
//   bar      LED bar pattern (bar[7] is the always-lit end), asynchronous to CLK
//   clr      synchronous clear of lock state and error counter
//   level    lit-LED count of the last accepted valid pattern (0 = no reference)
//   dir      0 = filling, 1 = emptying (meaningful while locked)
//   cnt_est  recovered phase count, 0 while unlocked
//   locked   high in LOCKED state
//   step     one-cycle pulse per legal accepted change
//   err      one-cycle pulse per illegal pattern or illegal transition
//   err_cnt  saturating error count
module led_bar_decoder #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic       CLK,
  input  logic       nrst,
  input  logic [7:0] bar,
  input  logic       clr,
  output logic [3:0] level,
  output logic       dir,
  output logic [3:0] cnt_est,
  output logic       locked,
  output logic       step,
  output logic       err,
  output logic [7:0] err_cnt
);

  localparam int unsigned RW = $clog2(STABLE_CYCLES + 1);
  localparam logic [RW-1:0] RUN_MAX = RW'(STABLE_CYCLES);

  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_ACQUIRE  = 2'd1,
    ST_LOCKED   = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [7:0]    s1, s2;
  logic [7:0]    cand, cand_nxt;
  logic [RW-1:0] run, run_nxt;
  logic [7:0]    last, last_nxt;
  logic          accept;
  logic [7:0]    pat_inv;
  logic          pat_valid;
  logic [3:0]    pat_len;
  logic [3:0]    exp_len;
  logic          exp_dir;
  logic [3:0]    level_nxt, cnt_nxt;
  logic          dir_nxt, step_nxt, err_nxt;
  logic [7:0]    err_cnt_nxt;

  // Stability filter: a pattern is accepted once, on the edge its run reaches the limit.
  always_comb begin
    cand_nxt = cand;
    run_nxt  = run;
    if (s2 != cand) begin
      cand_nxt = s2;
      run_nxt  = RW'(1);
    end else if (run != RUN_MAX) begin
      run_nxt = run + RW'(1);
    end
    accept = ((s2 != cand) || (run != RUN_MAX)) && (run_nxt == RUN_MAX) &&
             (cand_nxt != last);
    if (clr) begin
      run_nxt = '0;
      accept  = 1'b0;
    end
    last_nxt = clr ? 8'd0 : (accept ? cand_nxt : last);
  end

  // Legal pattern: bit 7 set and the zeros form a contiguous run at the low end.
  always_comb begin
    pat_inv   = ~cand_nxt;
    pat_valid = cand_nxt[7] && ((pat_inv & (pat_inv + 8'd1)) == 8'd0);
    pat_len   = 4'd0;
    for (int i = 0; i < 8; i++) begin
      pat_len = pat_len + 4'(cand_nxt[i]);
    end
  end

  // Only legal successor while locked; the ends reverse direction.
  always_comb begin
    exp_len = level;
    exp_dir = dir;
    if (!dir) begin
      if (level == 4'd8) begin
        exp_len = 4'd7;
        exp_dir = 1'b1;
      end else begin
        exp_len = level + 4'd1;
      end
    end else begin
      if (level == 4'd1) begin
        exp_len = 4'd2;
        exp_dir = 1'b0;
      end else begin
        exp_len = level - 4'd1;
      end
    end
  end

  // Next-state and output logic.
  always_comb begin
    state_nxt   = state;
    level_nxt   = level;
    dir_nxt     = dir;
    step_nxt    = 1'b0;
    err_nxt     = 1'b0;
    err_cnt_nxt = err_cnt;
    if (clr) begin
      state_nxt   = ST_UNLOCKED;
      level_nxt   = 4'd0;
      dir_nxt     = 1'b0;
      err_cnt_nxt = 8'd0;
    end else if (accept) begin
      if (!pat_valid) begin
        err_nxt   = 1'b1;
        state_nxt = ST_UNLOCKED;
        level_nxt = 4'd0;
      end else begin
        level_nxt = pat_len;
        case (state)
          ST_UNLOCKED: state_nxt = ST_ACQUIRE;
          ST_ACQUIRE: begin
            if (pat_len == level + 4'd1) begin
              state_nxt = ST_LOCKED;
              dir_nxt   = 1'b0;
              step_nxt  = 1'b1;
            end else if (pat_len == level - 4'd1) begin
              state_nxt = ST_LOCKED;
              dir_nxt   = 1'b1;
              step_nxt  = 1'b1;
            end else begin
              err_nxt = 1'b1;
            end
          end
          ST_LOCKED: begin
            if (pat_len == exp_len) begin
              dir_nxt  = exp_dir;
              step_nxt = 1'b1;
            end else begin
              err_nxt   = 1'b1;
              state_nxt = ST_ACQUIRE;
            end
          end
          default: begin
            state_nxt = ST_UNLOCKED;
            level_nxt = 4'd0;
          end
        endcase
      end
      if (err_nxt && (err_cnt != 8'hFF)) begin
        err_cnt_nxt = err_cnt + 8'd1;
      end
    end
    // Phases 7->8 and 15->0 are invisible, so 8 and 0 never show while locked.
    cnt_nxt = 4'd0;
    if (state_nxt == ST_LOCKED) begin
      cnt_nxt = dir_nxt ? 4'(5'd16 - {1'b0, level_nxt}) : (level_nxt - 4'd1);
    end
  end

  // State and output registers.
  always_ff @(posedge CLK or negedge nrst) begin
    if (!nrst) begin
      s1      <= 8'd0;
      s2      <= 8'd0;
      cand    <= 8'd0;
      run     <= '0;
      last    <= 8'd0;
      state   <= ST_UNLOCKED;
      level   <= 4'd0;
      dir     <= 1'b0;
      cnt_est <= 4'd0;
      locked  <= 1'b0;
      step    <= 1'b0;
      err     <= 1'b0;
      err_cnt <= 8'd0;
    end else begin
      s1      <= bar;
      s2      <= s1;
      cand    <= cand_nxt;
      run     <= run_nxt;
      last    <= last_nxt;
      state   <= state_nxt;
      level   <= level_nxt;
      dir     <= dir_nxt;
      cnt_est <= cnt_nxt;
      locked  <= (state_nxt == ST_LOCKED);
      step    <= step_nxt;
      err     <= err_nxt;
      err_cnt <= err_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_led_bar_decoder.sv
// Testbench for led_bar_decoder: behavioural phase-based reference model,
// directed scenarios with hand-computed expectations, then randomized stimulus.
module tb_led_bar_decoder;

  localparam int SC = 4;

  logic       CLK = 1'b0;
  logic       nrst;
  logic [7:0] bar;
  logic       clr;
  logic [3:0] level;
  logic       dir;
  logic [3:0] cnt_est;
  logic       locked;
  logic       step;
  logic       err;
  logic [7:0] err_cnt;

  led_bar_decoder #(.STABLE_CYCLES(SC)) dut (
    .CLK(CLK), .nrst(nrst), .bar(bar), .clr(clr),
    .level(level), .dir(dir), .cnt_est(cnt_est), .locked(locked),
    .step(step), .err(err), .err_cnt(err_cnt)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;
  int n_steps  = 0;
  int n_errs   = 0;

  // Reference model: pipeline of samples, run length, and the generator phase.
  logic [7:0] m_s1, m_s2, m_cand, m_last;
  int m_runlen, m_state, m_level, m_phase, m_errcnt, m_step, m_err;

  function automatic int lvl_of(int ph);
    return (ph < 8) ? ph + 1 : 16 - ph;
  endfunction

  function automatic logic [7:0] pat_of(int l);
    logic [7:0] f;
    f = 8'hFF;
    return f << (8 - l);
  endfunction

  function automatic int decode(logic [7:0] p);
    for (int l = 1; l <= 8; l++) if (p == pat_of(l)) return l;
    return -1;
  endfunction

  task automatic m_reset();
    m_s1 = 0; m_s2 = 0; m_cand = 0; m_last = 0;
    m_runlen = 0; m_state = 0; m_level = 0; m_phase = 0;
    m_errcnt = 0; m_step = 0; m_err = 0;
  endtask

  task automatic model_edge(logic [7:0] b, logic c);
    logic [7:0] v;
    int l, np;
    v = m_s2; m_s2 = m_s1; m_s1 = b;
    m_step = 0; m_err = 0;
    if (v != m_cand) begin
      m_cand = v; m_runlen = 1;
    end else begin
      m_runlen++;
    end
    if (c) begin
      m_runlen = 0; m_state = 0; m_level = 0; m_errcnt = 0; m_last = 0;
    end else if (m_runlen == SC && m_cand != m_last) begin
      m_last = m_cand;
      l = decode(m_cand);
      if (l < 0) begin
        m_err = 1; m_state = 0; m_level = 0;
      end else if (m_state == 0) begin
        m_state = 1; m_level = l;
      end else if (m_state == 1) begin
        if (l == m_level + 1) begin
          m_state = 2; m_phase = l - 1; m_step = 1;
        end else if (l == m_level - 1) begin
          m_state = 2; m_phase = 16 - l; m_step = 1;
        end else begin
          m_err = 1;
        end
        m_level = l;
      end else begin
        np = (m_phase + 1) % 16;
        if (lvl_of(np) == m_level) np = (np + 1) % 16;
        if (l == lvl_of(np)) begin
          m_phase = np; m_step = 1;
        end else begin
          m_err = 1; m_state = 1;
        end
        m_level = l;
      end
      if (m_err == 1 && m_errcnt < 255) m_errcnt++;
    end
  endtask

  task automatic chk(string name, logic [31:0] act, int expv);
    n_checks++;
    if (act !== 32'(expv)) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  // One clock edge: advance the model with the inputs seen at the edge, then compare.
  task automatic tick();
    @(posedge CLK);
    model_edge(bar, clr);
    #1;
    if (step) n_steps++;
    if (err) n_errs++;
    chk("level", 32'(level), m_level);
    chk("locked", 32'(locked), (m_state == 2) ? 1 : 0);
    chk("cnt_est", 32'(cnt_est), (m_state == 2) ? m_phase : 0);
    chk("step", 32'(step), m_step);
    chk("err", 32'(err), m_err);
    chk("err_cnt", 32'(err_cnt), m_errcnt);
    if (m_state == 2) chk("dir", 32'(dir), (m_phase >= 8) ? 1 : 0);
  endtask

  task automatic hold(logic [7:0] p, int n);
    bar = p;
    repeat (n) tick();
  endtask

  int s0, e0, ln, r, np;

  initial begin
    nrst = 1'b0; bar = 8'h00; clr = 1'b0;
    m_reset();
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_level", 32'(level), 0);
    chk("rst_locked", 32'(locked), 0);
    chk("rst_errcnt", 32'(err_cnt), 0);
    chk("rst_cnt", 32'(cnt_est), 0);
    nrst = 1'b1;
    // All-zero bar after reset never produces an event.
    hold(8'h00, 12);
    chk("zero_level", 32'(level), 0);

    // Two passes of the full 16-phase generator sequence.
    s0 = n_steps; e0 = n_errs;
    for (int pass = 0; pass < 2; pass++) begin
      for (int p = 0; p < 16; p++) begin
        hold(pat_of(lvl_of(p)), 10);
        if (pass == 0 && p == 1) chk("lock_after_2nd", 32'(locked), 1);
        if (pass == 1) chk("seq_cnt", 32'(cnt_est), (p == 0) ? 15 : (p == 8) ? 7 : p);
      end
    end
    chk("seq_steps", 32'(n_steps - s0), 28);
    chk("seq_errs", 32'(n_errs - e0), 0);
    chk("seq_end_dir", 32'(dir), 1);
    chk("seq_end_level", 32'(level), 1);

    // Latency: level 2 -> 3 exactly six edges after the change (E0+5).
    hold(8'hC0, 10);
    bar = 8'hE0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      chk("lat_level", 32'(level), (k == 6) ? 3 : 2);
      chk("lat_step", 32'(step), (k == 6) ? 1 : 0);
    end
    hold(8'hE0, 6);

    // Glitch shorter than the filter window.
    s0 = n_steps; e0 = n_errs;
    hold(8'hF0, 3);
    hold(8'hE0, 10);
    chk("glitch_steps", 32'(n_steps - s0), 0);
    chk("glitch_errs", 32'(n_errs - e0), 0);
    chk("glitch_level", 32'(level), 3);

    // Invalid pattern while locked, then relock.
    hold(8'hF0, 10);
    hold(8'hA0, 10);
    chk("inv_errcnt", 32'(err_cnt), 1);
    chk("inv_locked", 32'(locked), 0);
    chk("inv_level", 32'(level), 0);
    hold(8'hE0, 10);
    hold(8'hF0, 10);
    chk("relock", 32'(locked), 1);
    chk("relock_dir", 32'(dir), 0);

    // Illegal transition 4 -> 3 while filling.
    hold(8'hE0, 10);
    chk("ill_level", 32'(level), 3);
    chk("ill_locked", 32'(locked), 0);
    chk("ill_errcnt", 32'(err_cnt), 2);

    // Counter saturation.
    for (int i = 0; i < 260; i++) hold((i % 2) ? 8'h50 : 8'hA0, 5);
    chk("sat_errcnt", 32'(err_cnt), 255);

    // Clear in the same cycle as an accept.
    bar = 8'hC0;
    repeat (5) tick();
    clr = 1'b1;
    tick();
    chk("clr_errcnt", 32'(err_cnt), 0);
    chk("clr_step", 32'(step), 0);
    chk("clr_err", 32'(err), 0);
    chk("clr_level", 32'(level), 0);
    clr = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk("reacc_level", 32'(level), (k == 4) ? 2 : 0);
    end

    // Asynchronous reset mid-sequence.
    hold(8'hE0, 10);
    #2 nrst = 1'b0;
    #1;
    chk("arst_level", 32'(level), 0);
    chk("arst_locked", 32'(locked), 0);
    m_reset();
    #1 nrst = 1'b1;

    // Randomized segments, mostly legal sequencing with faults mixed in.
    for (int seg = 0; seg < 400; seg++) begin
      r = $urandom_range(0, 9);
      ln = $urandom_range(4, 12);
      if (r <= 4) begin
        if (m_state == 2) begin
          np = (m_phase + 1) % 16;
          if (lvl_of(np) == m_level) np = (np + 1) % 16;
          hold(pat_of(lvl_of(np)), ln);
        end else if (m_state == 1) begin
          if (m_level == 8 || (m_level > 1 && $urandom_range(0, 1) == 1))
            hold(pat_of(m_level - 1), ln);
          else
            hold(pat_of(m_level + 1), ln);
        end else begin
          hold(pat_of($urandom_range(1, 8)), ln);
        end
      end else if (r <= 6) begin
        hold(pat_of($urandom_range(1, 8)), ln);
      end else if (r == 7) begin
        hold(8'($urandom), ln);
      end else if (r == 8) begin
        hold(8'($urandom), $urandom_range(1, 3));
      end else begin
        clr = 1'b1;
        repeat ($urandom_range(1, 2)) tick();
        clr = 1'b0;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
